// File: rtl/d_reg_pipe.sv
// d_reg_pipe: elastic register pipeline of DEPTH stages, WIDTH bits wide.
// Each stage carries a valid bit. Empty stages always advance, so bubbles
// collapse while the output is stalled. Supports a synchronous flush and
// reports how many stages hold valid data.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   flush      synchronous clear of all valid bits (data is kept)
//   in_valid   producer presents in_data
//   in_data    input word
//   in_ready   pipeline accepts in_data this cycle
//   out_valid  last stage holds valid data
//   out_data   last-stage data
//   out_ready  consumer accepts out_data this cycle
//   count      number of valid stages (0..DEPTH)
module d_reg_pipe #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned DEPTH     = 3,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   localparam int unsigned CW       = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] data_q [DEPTH];
   logic [WIDTH-1:0] data_d [DEPTH];
   logic [DEPTH-1:0] v_q, v_d;
   logic [DEPTH-1:0] adv;
   logic [CW-1:0]    count_q, count_d;

   // A stage advances unless it and every stage downstream of it are valid
   // while the consumer stalls. Computed without a self-referencing chain.
   always_comb begin
      logic tail_full;
      tail_full = 1'b1;
      adv       = '0;
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
         tail_full = tail_full & v_q[i];
         adv[i]    = ~tail_full | out_ready;
      end
   end

   always_comb begin
      v_d     = v_q;
      count_d = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         data_d[i] = data_q[i];
      end
      if (flush) begin
         v_d = '0;
      end else begin
         // Stages load even when the incoming valid is 0.
         if (adv[0]) begin
            data_d[0] = in_data;
            v_d[0]    = in_valid;
         end
         for (int i = 1; i < int'(DEPTH); i++) begin
            if (adv[i]) begin
               data_d[i] = data_q[i-1];
               v_d[i]    = v_q[i-1];
            end
         end
      end
      for (int i = 0; i < int'(DEPTH); i++) begin
         count_d = count_d + CW'(v_d[i]);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v_q     <= '0;
         count_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            data_q[i] <= RESET_VAL;
         end
      end else begin
         v_q     <= v_d;
         count_q <= count_d;
         for (int i = 0; i < int'(DEPTH); i++) begin
            data_q[i] <= data_d[i];
         end
      end
   end

   // rst gates in_ready so nothing is accepted while reset is held.
   assign in_ready  = adv[0] & ~flush & rst;
   assign out_valid = v_q[DEPTH-1] & ~flush;
   assign out_data  = data_q[DEPTH-1];
   assign count     = count_q;

endmodule

// File: tb/tb_d_reg_pipe.sv
// Self-checking bench for d_reg_pipe (WIDTH=8, DEPTH=3, RESET_VAL=8'hA5).
// Reference model: a queue of accepted words, each tagged with its stage
// position. Each edge every word moves one stage forward unless the word
// ahead of it blocks; the oldest word leaves when presented and taken.
module tb_d_reg_pipe;

   localparam int WIDTH = 8;
   localparam int DEPTH = 3;
   localparam logic [7:0] RV = 8'hA5;

   logic       clk = 1'b0;
   logic       rst;
   logic       flush;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_ready;
   logic [1:0] count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] d;
      int         pos;
   } ent_t;
   ent_t mq[$];

   d_reg_pipe #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .RESET_VAL(RV)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .out_valid(out_valid),
      .out_data (out_data),
      .out_ready(out_ready),
      .count    (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic m_in_ready(input logic fl, input logic ordy);
      return !fl && (mq.size() < DEPTH || ordy);
   endfunction

   function automatic logic m_out_valid(input logic fl);
      return !fl && mq.size() > 0 && mq[0].pos == DEPTH - 1;
   endfunction

   // Entered at posedge+1: drive, check before the next edge, then advance model.
   task automatic cycle(input logic iv, input logic [7:0] id, input logic ordy, input logic fl);
      logic e_rdy, e_ov, acc, pop;
      int   lim, np;
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
      flush     = fl;
      e_rdy = m_in_ready(fl, ordy);
      e_ov  = m_out_valid(fl);
      #3;
      chk("in_ready", 32'(in_ready), 32'(e_rdy));
      chk("out_valid", 32'(out_valid), 32'(e_ov));
      chk("count", 32'(count), 32'(mq.size()));
      if (e_ov) chk("out_data", 32'(out_data), 32'(mq[0].d));
      acc = iv & e_rdy;
      pop = e_ov & ordy;
      @(posedge clk);
      #1;
      if (fl) begin
         mq.delete();
      end else begin
         if (pop) void'(mq.pop_front());
         lim = DEPTH - 1;
         foreach (mq[j]) begin
            np = (mq[j].pos + 1 < lim) ? mq[j].pos + 1 : lim;
            mq[j].pos = np;
            lim = np - 1;
         end
         if (acc) mq.push_back('{d: id, pos: 0});
      end
   endtask

   initial begin
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data", 32'(out_data), 32'(RV));
      chk("rst_count", 32'(count), 0);
      chk("rst_in_ready", 32'(in_ready), 0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Streaming
      for (int i = 1; i <= 16; i++) cycle(1'b1, 8'(i), 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

      // Stall / fill: 8'h44 is held at the producer
      cycle(1'b1, 8'h11, 1'b0, 1'b0);
      cycle(1'b1, 8'h22, 1'b0, 1'b0);
      cycle(1'b1, 8'h33, 1'b0, 1'b0);
      cycle(1'b1, 8'h44, 1'b0, 1'b0);
      cycle(1'b1, 8'h44, 1'b0, 1'b0);
      cycle(1'b1, 8'h44, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

      // Bubble collapse
      cycle(1'b1, 8'h55, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      cycle(1'b1, 8'h66, 1'b0, 1'b0);
      chk("bubble_count", 32'(count), 2);
      chk("bubble_out_valid", 32'(out_valid), 1);
      chk("bubble_out_data", 32'(out_data), 32'h55);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);

      // Full + simultaneous in/out
      cycle(1'b1, 8'h01, 1'b0, 1'b0);
      cycle(1'b1, 8'h02, 1'b0, 1'b0);
      cycle(1'b1, 8'h03, 1'b0, 1'b0);
      cycle(1'b1, 8'h77, 1'b1, 1'b0);
      chk("full_simul_count", 32'(count), 3);

      // Flush while full, with both sides requesting
      cycle(1'b1, 8'h88, 1'b1, 1'b1);
      chk("flush_count", 32'(count), 0);
      for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

      // Asynchronous reset mid-cycle with data in flight
      cycle(1'b1, 8'hC1, 1'b0, 1'b0);
      cycle(1'b1, 8'hC2, 1'b0, 1'b0);
      in_valid = 1'b0;
      #1 rst = 1'b0;
      #1;
      chk("mid_rst_out_valid", 32'(out_valid), 0);
      chk("mid_rst_out_data", 32'(out_data), 32'(RV));
      chk("mid_rst_count", 32'(count), 0);
      chk("mid_rst_in_ready", 32'(in_ready), 0);
      mq.delete();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) != 0),
               1'($urandom_range(0, 15) == 0));
      end
      for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
